round_key_store_writer: RTL and testbench

- Write-side controller for the round-key memory.
- During an encryption with a freshly changed key, it accepts the byte-serial round-key stream from the key expansion block. It writes round keys 1–9 into the key memory, so later operations fetch them from memory instead of re-expanding.
- It also generates the memory read address for the requested round/byte and reports when the stored schedule is complete and valid.
- It sits between key expansion and the key memory, in parallel with the round-key selection path to the core.

---
 rtl/round_key_store_writer.sv | 200 ++++++++++++++++++++
 tb/tb_round_key_store_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_store_writer.sv
// round_key_store_writer
//   Write-side controller for the round-key memory. While a fresh key schedule
//   streams out of key expansion (one byte per handshake, byte 0 first within
//   each round), round keys 1..9 are written into a byte-addressed memory at
//   (round-1)*16 + byte. Rounds 0 and 10 are accepted but never stored, since
//   they are always available without a memory fetch. A combinational read
//   address generator maps a requested round/byte onto the same map.
//
// Optional feature (compile-time macro): KEY_STORE_TAG_CHECK_EN
//   Defined   - every handshake compares rcon with the tag expected for the
//               current round; a mismatch drops the byte, sets sticky err and
//               aborts the capture back to IDLE.
//   Undefined - rcon is ignored and err is tied low.
//
// Ports
//   clk, rst_n         clock, synchronous active-low reset
//   start              one-cycle pulse: a new schedule is about to stream
//   rk_valid/rk_ready  byte handshake from key expansion
//   rk_data, rcon      round-key byte and its round tag
//   mem_we/waddr/wdata registered memory write port
//   rd_round, rd_byte  requested round/byte for reads
//   mem_raddr, rd_oob  combinational read address, out-of-range flag
//   busy               capture in progress
//   keys_valid         memory holds a complete schedule
//   err                sticky round-tag mismatch

module round_key_store_writer #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rk_valid,
  input  logic [WIDTH-1:0]  rk_data,
  input  logic [7:0]        rcon,
  output logic              rk_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [3:0]        rd_round,
  input  logic [3:0]        rd_byte,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic              rd_oob,
  output logic              busy,
  output logic              keys_valid,
  output logic              err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_round_cnt;
  logic [3:0]        r_byte_cnt;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_waddr;
  logic [WIDTH-1:0]  r_mem_wdata;
  logic              r_keys_valid;
  logic              r_err;

  logic              w_hs;
  logic              w_tag_bad;
  logic              w_hs_ok;
  logic              w_last;
  logic              w_store;
  logic [7:0]        w_waddr8;

`ifdef KEY_STORE_TAG_CHECK_EN
  // Tag that key expansion attaches to each round of the schedule.
  function automatic logic [7:0] exp_rcon(input logic [3:0] round);
    logic [7:0] tag;
    case (round)
      4'd0:    tag = 8'h01;
      4'd1:    tag = 8'h02;
      4'd2:    tag = 8'h04;
      4'd3:    tag = 8'h08;
      4'd4:    tag = 8'h10;
      4'd5:    tag = 8'h20;
      4'd6:    tag = 8'h40;
      4'd7:    tag = 8'h80;
      4'd8:    tag = 8'h1b;
      4'd9:    tag = 8'h36;
      4'd10:   tag = 8'h6c;
      default: tag = 8'h00;
    endcase
    return tag;
  endfunction

  assign w_tag_bad = w_hs && (rcon != exp_rcon(r_round_cnt));
`else
  logic w_unused_rcon;
  assign w_unused_rcon = ^rcon;
  assign w_tag_bad     = 1'b0;
`endif

  // start takes priority: a byte offered in the same cycle is discarded.
  assign w_hs     = (r_state == ST_FILL) && rk_valid && !start;
  assign w_hs_ok  = w_hs && !w_tag_bad;
  assign w_last   = w_hs_ok && (r_round_cnt == 4'd10) && (r_byte_cnt == 4'd15);
  assign w_store  = w_hs_ok && (r_round_cnt >= 4'd1) && (r_round_cnt <= 4'd9);
  // For rounds 1..9, {round-1, byte} is exactly (round-1)*16 + byte.
  assign w_waddr8 = {r_round_cnt - 4'd1, r_byte_cnt};

  // Next-state logic for the capture FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_FILL;
        else       w_state_nxt = ST_IDLE;
      end
      ST_FILL: begin
        if (start)          w_state_nxt = ST_FILL;
        else if (w_tag_bad) w_state_nxt = ST_IDLE;
        else if (w_last)    w_state_nxt = ST_DONE;
        else                w_state_nxt = ST_FILL;
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_FILL;
        else       w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, round/byte counters and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_round_cnt  <= 4'd0;
      r_byte_cnt   <= 4'd0;
      r_keys_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (start) begin
        r_round_cnt <= 4'd0;
        r_byte_cnt  <= 4'd0;
      end else if (w_hs_ok) begin
        r_byte_cnt <= r_byte_cnt + 4'd1;
        if (r_byte_cnt == 4'd15) r_round_cnt <= r_round_cnt + 4'd1;
        else                     r_round_cnt <= r_round_cnt;
      end else begin
        r_round_cnt <= r_round_cnt;
        r_byte_cnt  <= r_byte_cnt;
      end
      if (start || w_tag_bad) r_keys_valid <= 1'b0;
      else if (w_last)        r_keys_valid <= 1'b1;
      else                    r_keys_valid <= r_keys_valid;
      if (start)          r_err <= 1'b0;
      else if (w_tag_bad) r_err <= 1'b1;
      else                r_err <= r_err;
    end
  end

  // Registered memory write port: one-cycle mem_we per stored byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_waddr <= {ADDR_W{1'b0}};
      r_mem_wdata <= {WIDTH{1'b0}};
    end else begin
      r_mem_we <= w_store;
      if (w_store) begin
        r_mem_waddr <= ADDR_W'(w_waddr8);
        r_mem_wdata <= rk_data;
      end else begin
        r_mem_waddr <= r_mem_waddr;
        r_mem_wdata <= r_mem_wdata;
      end
    end
  end

  // Combinational read address; out-of-range rounds map to address 0.
  always_comb begin
    mem_raddr = {ADDR_W{1'b0}};
    rd_oob    = 1'b1;
    if ((rd_round >= 4'd1) && (rd_round <= 4'd9)) begin
      mem_raddr = ADDR_W'({rd_round - 4'd1, rd_byte});
      rd_oob    = 1'b0;
    end else begin
      mem_raddr = {ADDR_W{1'b0}};
      rd_oob    = 1'b1;
    end
  end

  assign rk_ready   = (r_state == ST_FILL);
  assign busy       = (r_state == ST_FILL);
  assign mem_we     = r_mem_we;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;
  assign keys_valid = r_keys_valid;
  assign err        = r_err;

endmodule

// File: tb/tb_round_key_store_writer.sv
// Directed testbench for round_key_store_writer. Expected write addresses and
// data are derived from the stream index: byte i belongs to round i/16, byte
// i%16, carries data i, and (for rounds 1..9) lands at address i-16.

module tb_round_key_store_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       rk_valid;
  logic [7:0] rk_data;
  logic [7:0] rcon;
  logic       rk_ready;
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [3:0] rd_round;
  logic [3:0] rd_byte;
  logic [7:0] mem_raddr;
  logic       rd_oob;
  logic       busy;
  logic       keys_valid;
  logic       err;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] tag_tbl [0:10];

  round_key_store_writer #(.WIDTH(8), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data),
    .rcon       (rcon),
    .rk_ready   (rk_ready),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .rd_round   (rd_round),
    .rd_byte    (rd_byte),
    .mem_raddr  (mem_raddr),
    .rd_oob     (rd_oob),
    .busy       (busy),
    .keys_valid (keys_valid),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // start pulse with a byte offered alongside it; the byte must be dropped.
  task automatic pulse_start;
    start    = 1'b1;
    rk_valid = 1'b1;
    rk_data  = 8'hEE;
    rcon     = 8'h01;
    tick;
    start    = 1'b0;
    rk_valid = 1'b0;
    chk("start_busy", busy, 32'd1);
    chk("start_ready", rk_ready, 32'd1);
    chk("start_kv", keys_valid, 32'd0);
    chk("start_err", err, 32'd0);
    chk("start_we", mem_we, 32'd0);
  endtask

  task automatic stream(input int n, input bit gap);
    for (int i = 0; i < n; i++) begin
      int   rnd;
      logic exp_we;
      rnd      = i / 16;
      rk_valid = 1'b1;
      rk_data  = 8'(i);
      rcon     = tag_tbl[rnd];
      tick;
      exp_we = (rnd >= 1) && (rnd <= 9);
      chk("wr_we", mem_we, exp_we);
      if (exp_we) begin
        chk("wr_addr", mem_waddr, i - 16);
        chk("wr_data", mem_wdata, i);
      end
      chk("kv", keys_valid, (i == 175));
      if (gap) begin
        rk_valid = 1'b0;
        rk_data  = 8'hA5;
        tick;
        chk("gap_we", mem_we, 32'd0);
        chk("gap_ready", rk_ready, (i != 175));
      end
    end
    rk_valid = 1'b0;
  endtask

  initial begin
    tag_tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                8'h40, 8'h80, 8'h1b, 8'h36, 8'h6c};
    rst_n    = 1'b0;
    start    = 1'b0;
    rk_valid = 1'b0;
    rk_data  = 8'h00;
    rcon     = 8'h00;
    rd_round = 4'd0;
    rd_byte  = 4'd0;
    tick;
    tick;
    rst_n = 1'b1;

    // Reset values
    chk("rst_ready", rk_ready, 32'd0);
    chk("rst_we", mem_we, 32'd0);
    chk("rst_busy", busy, 32'd0);
    chk("rst_kv", keys_valid, 32'd0);
    chk("rst_err", err, 32'd0);
    chk("rst_waddr", mem_waddr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);

    // rk_valid in IDLE is ignored
    rk_valid = 1'b1;
    rk_data  = 8'h33;
    rcon     = 8'h02;
    tick;
    rk_valid = 1'b0;
    chk("idle_we", mem_we, 32'd0);
    chk("idle_busy", busy, 32'd0);

    // Combinational read address
    rd_round = 4'd5;  rd_byte = 4'd7;  #1;
    chk("rd_5_7", mem_raddr, 32'd71);
    chk("rd_5_7_oob", rd_oob, 32'd0);
    rd_round = 4'd0;  rd_byte = 4'd3;  #1;
    chk("rd_0", mem_raddr, 32'd0);
    chk("rd_0_oob", rd_oob, 32'd1);
    rd_round = 4'd10; rd_byte = 4'd3;  #1;
    chk("rd_10", mem_raddr, 32'd0);
    chk("rd_10_oob", rd_oob, 32'd1);
    rd_round = 4'd9;  rd_byte = 4'd15; #1;
    chk("rd_9_15", mem_raddr, 32'd143);
    chk("rd_9_15_oob", rd_oob, 32'd0);
    rd_round = 4'd1;  rd_byte = 4'd0;  #1;
    chk("rd_1_0", mem_raddr, 32'd0);
    chk("rd_1_0_oob", rd_oob, 32'd0);

    // Full back-to-back schedule
    pulse_start;
    stream(176, 1'b0);
    chk("full_busy", busy, 32'd0);

    // DONE ignores rk_valid and holds keys_valid
    rk_valid = 1'b1;
    rk_data  = 8'h55;
    tick;
    rk_valid = 1'b0;
    chk("done_we", mem_we, 32'd0);
    chk("done_kv", keys_valid, 32'd1);

    // Schedule with a gap after every byte
    pulse_start;
    stream(176, 1'b1);

    // Restart after 40 bytes
    pulse_start;
    stream(40, 1'b0);
    pulse_start;
    stream(176, 1'b0);

    // Round 3 byte 0 carries a wrong tag
    pulse_start;
    stream(48, 1'b0);
    rk_valid = 1'b1;
    rk_data  = 8'd48;
    rcon     = 8'h10;
    tick;
    rk_valid = 1'b0;
`ifdef KEY_STORE_TAG_CHECK_EN
    chk("tag_we", mem_we, 32'd0);
    chk("tag_err", err, 32'd1);
    chk("tag_busy", busy, 32'd0);
    chk("tag_kv", keys_valid, 32'd0);
    tick;
    chk("tag_err_sticky", err, 32'd1);
    pulse_start;
`else
    chk("notag_we", mem_we, 32'd1);
    chk("notag_addr", mem_waddr, 32'd32);
    chk("notag_data", mem_wdata, 32'd48);
    chk("notag_err", err, 32'd0);
    chk("notag_busy", busy, 32'd1);
`endif

    // Reset for one cycle in the middle of round 4
    pulse_start;
    stream(70, 1'b0);
    rk_valid = 1'b1;
    rk_data  = 8'd70;
    rcon     = 8'h10;
    rst_n    = 1'b0;
    tick;
    rst_n    = 1'b1;
    chk("mrst_we", mem_we, 32'd0);
    chk("mrst_ready", rk_ready, 32'd0);
    chk("mrst_busy", busy, 32'd0);
    chk("mrst_kv", keys_valid, 32'd0);
    chk("mrst_err", err, 32'd0);
    chk("mrst_waddr", mem_waddr, 32'd0);
    chk("mrst_wdata", mem_wdata, 32'd0);
    for (int k = 0; k < 3; k++) begin
      rk_data = 8'(71 + k);
      tick;
      chk("post_rst_we", mem_we, 32'd0);
      chk("post_rst_busy", busy, 32'd0);
    end
    rk_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
